// File: rtl/simple_axi_slave_mem.sv
// Single-beat AXI4 responder backed by a 64-bit-wide register memory.
// Independent write (AW/W/B) and read (AR/R) FSMs; OKAY/SLVERR/DECERR responses.
module simple_axi_slave_mem #(
  parameter int          C_ADDR_BITS   = 6,
  parameter logic [31:0] C_BASE_ADDR   = 32'h0000_0000,
  parameter int          C_WAIT_CYCLES = 0
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awsize,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic        s_axi_wlast,
  input  logic [63:0] s_axi_wdata,
  input  logic [7:0]  s_axi_wstrb,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arsize,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        s_axi_rlast,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp
);

  localparam int         DEPTH       = 1 << C_ADDR_BITS;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam bit         HAS_WAIT    = (C_WAIT_CYCLES > 0);
  localparam logic [3:0] WAIT_INIT   = HAS_WAIT ? 4'(C_WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  // An address below the base wraps to an offset >= span, so one range test covers both ends.
  function automatic logic [1:0] resp_of(input logic [31:0] addr, input logic [2:0] size,
                                         input logic last);
    logic [31:0] offset;
    logic [2:0]  low;
    offset = addr - C_BASE_ADDR;
    case (size)
      3'd1:    low = {2'b00, addr[0]};
      3'd2:    low = {1'b0, addr[1:0]};
      3'd3:    low = addr[2:0];
      default: low = 3'd0;
    endcase
    if ((offset >> (C_ADDR_BITS + 3)) != 32'd0)
      resp_of = RESP_DECERR;
    else if (size > 3'd3 || low != 3'd0 || !last)
      resp_of = RESP_SLVERR;
    else
      resp_of = RESP_OKAY;
  endfunction

  function automatic logic [C_ADDR_BITS-1:0] word_idx(input logic [31:0] addr);
    word_idx = C_ADDR_BITS'((addr - C_BASE_ADDR) >> 3);
  endfunction

  logic [63:0] mem [0:DEPTH-1];

  logic                   live;
  w_state_t               w_state, w_state_nxt;
  r_state_t               r_state, r_state_nxt;
  logic [3:0]             w_cnt, w_cnt_nxt, r_cnt, r_cnt_nxt;
  logic                   aw_vld_p0, w_vld_p0;
  logic [31:0]            aw_addr_p0;
  logic [2:0]             aw_size_p0;
  logic [63:0]            w_data_p0;
  logic [7:0]             w_strb_p0;
  logic                   w_last_p0;
  logic                   aw_hs, w_hs, ar_hs, commit;
  logic [31:0]            wr_addr;
  logic [2:0]             wr_size;
  logic [63:0]            wr_data;
  logic [7:0]             wr_strb;
  logic                   wr_last;
  logic [1:0]             wr_resp, rd_resp;
  logic [C_ADDR_BITS-1:0] wr_idx, rd_idx;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // Commit uses a latched channel if held, otherwise the one handshaking this edge.
  assign wr_addr = aw_vld_p0 ? aw_addr_p0 : s_axi_awaddr;
  assign wr_size = aw_vld_p0 ? aw_size_p0 : s_axi_awsize;
  assign wr_data = w_vld_p0 ? w_data_p0 : s_axi_wdata;
  assign wr_strb = w_vld_p0 ? w_strb_p0 : s_axi_wstrb;
  assign wr_last = w_vld_p0 ? w_last_p0 : s_axi_wlast;
  assign wr_resp = resp_of(wr_addr, wr_size, wr_last);
  assign wr_idx  = word_idx(wr_addr);
  assign rd_resp = resp_of(s_axi_araddr, s_axi_arsize, 1'b1);
  assign rd_idx  = word_idx(s_axi_araddr);

  always_comb begin
    w_state_nxt   = w_state;
    w_cnt_nxt     = w_cnt;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    commit        = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi_awready = live && !aw_vld_p0;
        s_axi_wready  = live && !w_vld_p0;
        commit = (aw_vld_p0 || (s_axi_awvalid && s_axi_awready)) &&
                 (w_vld_p0 || (s_axi_wvalid && s_axi_wready));
        if (commit) begin
          w_state_nxt = HAS_WAIT ? W_WAIT : W_RESP;
          w_cnt_nxt   = WAIT_INIT;
        end
      end
      W_WAIT: begin
        if (w_cnt == 4'd0) w_state_nxt = W_RESP;
        else               w_cnt_nxt   = w_cnt - 4'd1;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt   = r_state;
    r_cnt_nxt     = r_cnt;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi_arready = live;
        if (s_axi_arvalid && live) begin
          r_state_nxt = HAS_WAIT ? R_WAIT : R_DATA;
          r_cnt_nxt   = WAIT_INIT;
        end
      end
      R_WAIT: begin
        if (r_cnt == 4'd0) r_state_nxt = R_DATA;
        else               r_cnt_nxt   = r_cnt - 4'd1;
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        s_axi_rlast  = 1'b1;
        if (s_axi_rready) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Control state and responses
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      live        <= 1'b0;
      w_state     <= W_IDLE;
      r_state     <= R_IDLE;
      w_cnt       <= 4'd0;
      r_cnt       <= 4'd0;
      aw_vld_p0   <= 1'b0;
      w_vld_p0    <= 1'b0;
      s_axi_bresp <= RESP_OKAY;
      s_axi_rresp <= RESP_OKAY;
      s_axi_rdata <= 64'd0;
    end else begin
      live    <= 1'b1;
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
      w_cnt   <= w_cnt_nxt;
      r_cnt   <= r_cnt_nxt;
      if (commit) begin
        aw_vld_p0   <= 1'b0;
        w_vld_p0    <= 1'b0;
        s_axi_bresp <= wr_resp;
      end else begin
        if (aw_hs) aw_vld_p0 <= 1'b1;
        if (w_hs)  w_vld_p0  <= 1'b1;
      end
      if (ar_hs) begin
        s_axi_rresp <= rd_resp;
        s_axi_rdata <= (rd_resp == RESP_OKAY) ? mem[rd_idx] : 64'd0;
      end
    end
  end

  // Latched channel payloads
  always_ff @(posedge i_clk) begin
    if (aw_hs) begin
      aw_addr_p0 <= s_axi_awaddr;
      aw_size_p0 <= s_axi_awsize;
    end
    if (w_hs) begin
      w_data_p0 <= s_axi_wdata;
      w_strb_p0 <= s_axi_wstrb;
      w_last_p0 <= s_axi_wlast;
    end
  end

  // Memory array, byte-lane writes on a clean commit
  always_ff @(posedge i_clk) begin
    if (commit && wr_resp == RESP_OKAY) begin
      for (int i = 0; i < 8; i++) begin
        if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_simple_axi_slave_mem.sv
// Bench for simple_axi_slave_mem: a zero-wait instance for function/errors/reset
// and a three-wait instance for response timing and backpressure.
`timescale 1ns/1ps
module tb_simple_axi_slave_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] awaddr, araddr;
  logic [2:0]  awsize, arsize;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;
  logic [1:0]  bresp, rresp;

  logic        d3_awvalid, d3_awready, d3_wvalid, d3_wready, d3_wlast, d3_bvalid, d3_bready;
  logic        d3_arvalid, d3_arready, d3_rvalid, d3_rready, d3_rlast;
  logic [31:0] d3_awaddr, d3_araddr;
  logic [2:0]  d3_awsize, d3_arsize;
  logic [63:0] d3_wdata, d3_rdata;
  logic [7:0]  d3_wstrb;
  logic [1:0]  d3_bresp, d3_rresp;

  simple_axi_slave_mem #(.C_ADDR_BITS(6), .C_BASE_ADDR(32'h0), .C_WAIT_CYCLES(0)) dut0 (
    .i_clk(clk), .i_rstn(rstn),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awsize(awsize),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wlast(wlast), .s_axi_wdata(wdata),
    .s_axi_wstrb(wstrb), .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arsize(arsize),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rlast(rlast), .s_axi_rdata(rdata),
    .s_axi_rresp(rresp)
  );

  simple_axi_slave_mem #(.C_ADDR_BITS(6), .C_BASE_ADDR(32'h0), .C_WAIT_CYCLES(3)) dut3 (
    .i_clk(clk), .i_rstn(rstn),
    .s_axi_awvalid(d3_awvalid), .s_axi_awready(d3_awready), .s_axi_awaddr(d3_awaddr),
    .s_axi_awsize(d3_awsize), .s_axi_wvalid(d3_wvalid), .s_axi_wready(d3_wready),
    .s_axi_wlast(d3_wlast), .s_axi_wdata(d3_wdata), .s_axi_wstrb(d3_wstrb),
    .s_axi_bvalid(d3_bvalid), .s_axi_bready(d3_bready), .s_axi_bresp(d3_bresp),
    .s_axi_arvalid(d3_arvalid), .s_axi_arready(d3_arready), .s_axi_araddr(d3_araddr),
    .s_axi_arsize(d3_arsize), .s_axi_rvalid(d3_rvalid), .s_axi_rready(d3_rready),
    .s_axi_rlast(d3_rlast), .s_axi_rdata(d3_rdata), .s_axi_rresp(d3_rresp)
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic [63:0] ref_mem [0:63];
  logic [1:0]  exp_b_q [$];
  rexp_t       exp_r_q [$];

  // Reference model of the zero-wait instance: 512-byte span at base 0.
  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [2:0] size,
                                             input logic [63:0] data, input logic [7:0] strb,
                                             input logic last);
    logic [5:0] idx;
    if (addr >= 32'h200) return 2'b11;
    if (size > 3'd3 || (addr & ((32'd1 << size) - 32'd1)) != 32'd0 || !last) return 2'b10;
    idx = addr[8:3];
    for (int i = 0; i < 8; i++)
      if (strb[i]) ref_mem[idx][8*i +: 8] = data[8*i +: 8];
    return 2'b00;
  endfunction

  function automatic rexp_t model_read(input logic [31:0] addr, input logic [2:0] size);
    rexp_t r;
    logic [5:0] idx;
    r.data = 64'd0;
    if (addr >= 32'h200) r.resp = 2'b11;
    else if (size > 3'd3 || (addr & ((32'd1 << size) - 32'd1)) != 32'd0) r.resp = 2'b10;
    else begin
      idx    = addr[8:3];
      r.resp = 2'b00;
      r.data = ref_mem[idx];
    end
    return r;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [2:0] size, input logic [63:0] data,
                           input logic [7:0] strb, input logic last, input int w_lead,
                           output logic [1:0] resp, output int b_lat, output bit got);
    bit aw_done, w_done, aw_hit, w_hit;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    awaddr = addr; awsize = size; wdata = data; wstrb = strb; wlast = last;
    wvalid = 1'b1;
    awvalid = (w_lead == 0);
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge clk);
      aw_hit = awvalid && awready;
      w_hit  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hit) begin aw_done = 1; awvalid = 1'b0; end
      if (w_hit)  begin w_done = 1;  wvalid = 1'b0;  end
      cyc++;
      if (!aw_done && cyc >= w_lead) awvalid = 1'b1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    got = 0; b_lat = 0; resp = 2'bxx;
    bready = 1'b1;
    while (!got && b_lat < 40) begin
      @(negedge clk);
      b_lat++;
      if (bvalid) begin got = 1; resp = bresp; end
      @(posedge clk); #1;
    end
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [2:0] size, output logic [63:0] data,
                          output logic [1:0] resp, output logic last, output int r_lat,
                          output bit got);
    bit hit;
    int cyc;
    hit = 0; cyc = 0;
    araddr = addr; arsize = size; arvalid = 1'b1;
    while (!hit && cyc < 40) begin
      @(negedge clk);
      hit = arready;
      @(posedge clk); #1;
      cyc++;
    end
    arvalid = 1'b0;
    got = 0; r_lat = 0; data = 'x; resp = 'x; last = 1'bx;
    rready = 1'b1;
    while (hit && !got && r_lat < 40) begin
      @(negedge clk);
      r_lat++;
      if (rvalid) begin got = 1; data = rdata; resp = rresp; last = rlast; end
      @(posedge clk); #1;
    end
    rready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, rlast} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b want=000000", {awready, wready, arready, bvalid, rvalid, rlast});
    end
    checks++;
    if ({bresp, rresp, rdata} !== 68'd0) begin
      failures++; $display("FAIL reset_data bresp=%b rresp=%b rdata=%h want 0", bresp, rresp, rdata);
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      failures++; $display("FAIL ready_before_live got=%b want=000", {awready, wready, arready});
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({awready, wready, arready, d3_arready} !== 4'b1111) begin
      failures++; $display("FAIL ready_after_live got=%b want=1111", {awready, wready, arready, d3_arready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [1:0] resp; logic [63:0] d; logic l; int lat; bit got; logic [1:0] eb; rexp_t er;
    exp_b_q.push_back(model_write(32'h10, 3'd3, 64'h1122334455667788, 8'hFF, 1'b1));
    axi_write(32'h10, 3'd3, 64'h1122334455667788, 8'hFF, 1'b1, 0, resp, lat, got);
    eb = exp_b_q.pop_front();
    checks++;
    if (!got || resp !== eb || lat !== 1) begin
      failures++; $display("FAIL wr_full got=%0b resp=%b lat=%0d want resp=%b lat=1", got, resp, lat, eb);
    end
    exp_r_q.push_back(model_read(32'h10, 3'd3));
    axi_read(32'h10, 3'd3, d, resp, l, lat, got);
    er = exp_r_q.pop_front();
    checks++;
    if (!got || d !== er.data || resp !== er.resp) begin
      failures++; $display("FAIL rd_full got=%0b data=%h resp=%b want data=%h resp=%b", got, d, resp, er.data, er.resp);
    end
    checks++;
    if (l !== 1'b1 || lat !== 1) begin
      failures++; $display("FAIL rd_latency rlast=%b lat=%0d want rlast=1 lat=1", l, lat);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] resp; logic [63:0] d; logic l; int lat, extra; bit got; logic [1:0] eb; rexp_t er;
    exp_b_q.push_back(model_write(32'h14, 3'd2, 64'hAABBCCDD_00000000, 8'hF0, 1'b1));
    axi_write(32'h14, 3'd2, 64'hAABBCCDD_00000000, 8'hF0, 1'b1, 3, resp, lat, got);
    eb = exp_b_q.pop_front();
    checks++;
    if (!got || resp !== eb) begin
      failures++; $display("FAIL w_first_resp got=%0b resp=%b want=%b", got, resp, eb);
    end
    extra = 0;
    bready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bvalid) extra++;
      @(posedge clk); #1;
    end
    bready = 1'b0;
    checks++;
    if (extra !== 0) begin
      failures++; $display("FAIL w_first_single_b extra=%0d want=0", extra);
    end
    exp_r_q.push_back(model_read(32'h10, 3'd3));
    axi_read(32'h10, 3'd3, d, resp, l, lat, got);
    er = exp_r_q.pop_front();
    checks++;
    if (!got || d !== er.data || d !== 64'hAABBCCDD55667788 || resp !== er.resp) begin
      failures++; $display("FAIL w_first_merge data=%h resp=%b want data=%h resp=%b", d, resp, er.data, er.resp);
    end
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } wvec_t;

  task automatic test_errors();
    logic [1:0] resp; logic [63:0] d; logic l; int lat; bit got; logic [1:0] eb; rexp_t er;
    wvec_t wv [0:5];
    logic [31:0] ra [0:3];
    logic [2:0]  rs [0:3];
    wv[0] = '{32'h18, 3'd3, 64'h0123456789ABCDEF, 8'hFF, 1'b1};
    wv[1] = '{32'h12, 3'd2, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 1'b1};
    wv[2] = '{32'h18, 3'd4, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 1'b1};
    wv[3] = '{32'h18, 3'd3, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 1'b0};
    wv[4] = '{32'h201, 3'd2, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 1'b1};
    wv[5] = '{32'h18, 3'd3, 64'hFFFFFFFF_FFFFFFFF, 8'h00, 1'b1};
    for (int i = 0; i < 6; i++) begin
      exp_b_q.push_back(model_write(wv[i].addr, wv[i].size, wv[i].data, wv[i].strb, wv[i].last));
      axi_write(wv[i].addr, wv[i].size, wv[i].data, wv[i].strb, wv[i].last, 0, resp, lat, got);
      eb = exp_b_q.pop_front();
      checks++;
      if (!got || resp !== eb) begin
        failures++; $display("FAIL err_wr[%0d] got=%0b bresp=%b want=%b", i, got, resp, eb);
      end
    end
    ra[0] = 32'h200; rs[0] = 3'd3;
    ra[1] = 32'h10;  rs[1] = 3'd3;
    ra[2] = 32'h18;  rs[2] = 3'd3;
    ra[3] = 32'h0C;  rs[3] = 3'd3;
    for (int i = 0; i < 4; i++) begin
      exp_r_q.push_back(model_read(ra[i], rs[i]));
      axi_read(ra[i], rs[i], d, resp, l, lat, got);
      er = exp_r_q.pop_front();
      checks++;
      if (!got || d !== er.data || resp !== er.resp) begin
        failures++; $display("FAIL err_rd[%0d] got=%0b data=%h resp=%b want data=%h resp=%b", i, got, d, resp, er.data, er.resp);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] wresp, rrsp; logic [63:0] d; logic l; int wl, rl; bit wg, rg; logic [1:0] eb; rexp_t er;
    exp_b_q.push_back(model_write(32'h08, 3'd3, 64'h0BAD_F00D_0BAD_F00D, 8'hFF, 1'b1));
    axi_write(32'h08, 3'd3, 64'h0BAD_F00D_0BAD_F00D, 8'hFF, 1'b1, 0, wresp, wl, wg);
    eb = exp_b_q.pop_front();
    checks++;
    if (!wg || wresp !== eb) begin
      failures++; $display("FAIL simul_pre got=%0b bresp=%b want=%b", wg, wresp, eb);
    end
    exp_r_q.push_back(model_read(32'h08, 3'd3));
    exp_b_q.push_back(model_write(32'h08, 3'd3, 64'h5555_AAAA_1234_5678, 8'hFF, 1'b1));
    fork
      axi_write(32'h08, 3'd3, 64'h5555_AAAA_1234_5678, 8'hFF, 1'b1, 0, wresp, wl, wg);
      axi_read(32'h08, 3'd3, d, rrsp, l, rl, rg);
    join
    er = exp_r_q.pop_front();
    eb = exp_b_q.pop_front();
    checks++;
    if (!rg || d !== er.data || rrsp !== er.resp) begin
      failures++; $display("FAIL simul_old data=%h resp=%b want data=%h resp=%b", d, rrsp, er.data, er.resp);
    end
    checks++;
    if (!wg || wresp !== eb) begin
      failures++; $display("FAIL simul_wr got=%0b bresp=%b want=%b", wg, wresp, eb);
    end
    exp_r_q.push_back(model_read(32'h08, 3'd3));
    axi_read(32'h08, 3'd3, d, rrsp, l, rl, rg);
    er = exp_r_q.pop_front();
    checks++;
    if (!rg || d !== er.data || d !== 64'h5555_AAAA_1234_5678) begin
      failures++; $display("FAIL simul_new data=%h want=%h", d, er.data);
    end
  endtask

  task automatic test_wait_cycles();
    int k, aw_early, unstable;
    bit got, hit;
    logic [1:0] rec, eb;
    d3_awaddr = 32'h20; d3_awsize = 3'd3; d3_wdata = 64'hCAFE_BABE_DEAD_BEEF;
    d3_wstrb = 8'hFF; d3_wlast = 1'b1; d3_bready = 1'b0;
    d3_awvalid = 1'b1; d3_wvalid = 1'b1;
    exp_b_q.push_back(2'b00);
    hit = 0; k = 0;
    while (!hit && k < 20) begin
      @(negedge clk);
      hit = d3_awready && d3_wready;
      @(posedge clk); #1;
      k++;
    end
    d3_awvalid = 1'b0; d3_wvalid = 1'b0;
    d3_awaddr = 32'h28; d3_awvalid = 1'b1;
    k = 0; got = 0; aw_early = 0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (d3_bvalid) got = 1;
      if (d3_awready) aw_early++;
      if (!got) begin @(posedge clk); #1; end
    end
    eb = exp_b_q.pop_front();
    checks++;
    if (!got || k !== 4) begin
      failures++; $display("FAIL wait_b_latency got=%0b cycles=%0d want=4", got, k);
    end
    rec = d3_bresp;
    checks++;
    if (rec !== eb) begin
      failures++; $display("FAIL wait_bresp got=%b want=%b", rec, eb);
    end
    unstable = 0;
    repeat (5) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!d3_bvalid || d3_bresp !== rec) unstable++;
      if (d3_awready) aw_early++;
    end
    checks++;
    if (unstable !== 0 || aw_early !== 0) begin
      failures++; $display("FAIL wait_backpressure unstable=%0d aw_accepted=%0d want 0/0", unstable, aw_early);
    end
    d3_bready = 1'b1;
    @(posedge clk); #1;
    d3_bready = 1'b0;
    @(negedge clk);
    checks++;
    if (d3_bvalid !== 1'b0 || d3_awready !== 1'b1) begin
      failures++; $display("FAIL wait_after_b bvalid=%b awready=%b want 0/1", d3_bvalid, d3_awready);
    end
    @(posedge clk); #1;
    d3_awvalid = 1'b0;
    d3_wdata = 64'h1111_2222_3333_4444; d3_wvalid = 1'b1;
    hit = 0; k = 0;
    while (!hit && k < 20) begin
      @(negedge clk);
      hit = d3_wready;
      @(posedge clk); #1;
      k++;
    end
    d3_wvalid = 1'b0;
    d3_bready = 1'b1;
    got = 0; k = 0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (d3_bvalid) begin got = 1; rec = d3_bresp; end
      @(posedge clk); #1;
    end
    d3_bready = 1'b0;
    checks++;
    if (!got || rec !== 2'b00 || k !== 4) begin
      failures++; $display("FAIL wait_second_b got=%0b bresp=%b cycles=%0d want 00/4", got, rec, k);
    end
    d3_araddr = 32'h20; d3_arsize = 3'd3; d3_arvalid = 1'b1;
    hit = 0; k = 0;
    while (!hit && k < 20) begin
      @(negedge clk);
      hit = d3_arready;
      @(posedge clk); #1;
      k++;
    end
    d3_arvalid = 1'b0;
    d3_rready = 1'b1;
    got = 0; k = 0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (d3_rvalid) got = 1;
      if (!got) begin @(posedge clk); #1; end
    end
    checks++;
    if (!got || k !== 4 || d3_rdata !== 64'hCAFE_BABE_DEAD_BEEF || d3_rlast !== 1'b1) begin
      failures++; $display("FAIL wait_read got=%0b cycles=%0d data=%h want 4 CAFEBABEDEADBEEF", got, k, d3_rdata);
    end
    @(posedge clk); #1;
    d3_rready = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    bit hit; int k, beats; logic [1:0] resp; logic [63:0] d; logic l; int lat; bit got; rexp_t er;
    araddr = 32'h10; arsize = 3'd3; arvalid = 1'b1; rready = 1'b0;
    hit = 0; k = 0;
    while (!hit && k < 20) begin
      @(negedge clk);
      hit = arready;
      @(posedge clk); #1;
      k++;
    end
    arvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b1) begin
      failures++; $display("FAIL mid_rvalid_before got=%b want=1", rvalid);
    end
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({rvalid, rlast, arready} !== 3'b000) begin
      failures++; $display("FAIL mid_async_drop got=%b want=000", {rvalid, rlast, arready});
    end
    rready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({arready, awready, wready, rvalid} !== 4'b0000) begin
      failures++; $display("FAIL mid_first_cycle got=%b want=0000", {arready, awready, wready, rvalid});
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({arready, awready, wready} !== 3'b111) begin
      failures++; $display("FAIL mid_second_cycle got=%b want=111", {arready, awready, wready});
    end
    beats = 0;
    repeat (4) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (rvalid) beats++;
    end
    @(posedge clk); #1;
    rready = 1'b0;
    checks++;
    if (beats !== 0) begin
      failures++; $display("FAIL mid_no_beat beats=%0d want=0", beats);
    end
    exp_r_q.push_back(model_read(32'h10, 3'd3));
    axi_read(32'h10, 3'd3, d, resp, l, lat, got);
    er = exp_r_q.pop_front();
    checks++;
    if (!got || d !== er.data || resp !== er.resp) begin
      failures++; $display("FAIL mem_retained data=%h resp=%b want data=%h resp=%b", d, resp, er.data, er.resp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    {awvalid, wvalid, wlast, bready, arvalid, rready} = '0;
    awaddr = '0; araddr = '0; awsize = '0; arsize = '0; wdata = '0; wstrb = '0;
    {d3_awvalid, d3_wvalid, d3_wlast, d3_bready, d3_arvalid, d3_rready} = '0;
    d3_awaddr = '0; d3_araddr = '0; d3_awsize = '0; d3_arsize = '0; d3_wdata = '0; d3_wstrb = '0;
    test_reset();
    test_write_read();
    test_w_before_aw();
    test_errors();
    test_simultaneous();
    test_wait_cycles();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
